// File: rtl/sfifo_wr_if_top.sv
// sfifo_wr_if_top: Wishbone slave that turns host writes into pushes on a
// synchronous FIFO. This is the host-to-motion/IO command path that carries
// SYNC_JNT, SYNC_DOUT and SYNC_DI command words.
//
// Register map (adr[4:2]):
//   0 DATA16 (W)  push dat[15:0]
//   1 DATA32 (W)  push dat[15:0], then dat[31:16]
//   2 CTRL   (RW) read {29'd0, abort, busy, full}; write bit2=1 clears abort
//   3 CNT    (RW) push counter when SFIFO_WR_CNT_EN is defined, else reads 0
//   4-7           read 0, writes acked and ignored
//
// Optional feature macro: SFIFO_WR_CNT_EN builds the 32-bit push counter.
//
// Pushes are never issued on back-to-back cycles, so sfifo_full_i is always
// re-sampled after a push before the next push is decided. The two halves of
// a DATA32 write are always pushed as a pair, even if the master abandons the
// cycle in between; that case is flagged through the sticky abort bit.
module sfifo_wr_if_top #(
    parameter int WB_LAW   = 5,
    parameter int WB_DW    = 32,
    parameter int SFIFO_DW = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic                wb_we_i,
    input  logic [3:0]          wb_sel_i,
    input  logic [WB_LAW-1:0]   wb_adr_i,
    input  logic [WB_DW-1:0]    wb_dat_i,
    output logic [WB_DW-1:0]    wb_dat_o,
    output logic                wb_ack_o,
    output logic                sfifo_wr_o,
    output logic [SFIFO_DW-1:0] sfifo_do,
    input  logic                sfifo_full_i
);

    localparam logic [2:0] OFF_DATA16 = 3'd0;
    localparam logic [2:0] OFF_DATA32 = 3'd1;
    localparam logic [2:0] OFF_CTRL   = 3'd2;
    localparam logic [2:0] OFF_CNT    = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_HI   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                ack_q, ack_d;
    logic [WB_DW-1:0]    dat_q, dat_d;
    logic                wr_q, wr_d;
    logic [SFIFO_DW-1:0] do_q, do_d;
    logic [SFIFO_DW-1:0] hi_q, hi_d;
    logic                abort_q, abort_d;
    logic                abort_set;
    logic                abort_clr;
    logic                req;
    logic                busy;
    logic [2:0]          off;
    logic                is_data;
    logic [WB_DW-1:0]    rd_data;
`ifdef SFIFO_WR_CNT_EN
    logic                cnt_clr;
    logic [31:0]         cnt_q, cnt_d;
`endif

    // Byte selects and the byte-offset address bits play no part: every
    // access is treated as a full-word access.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, wb_sel_i, wb_adr_i[1:0]};

    // A new request is only seen when the previous one is not being acked,
    // so every ack cycle doubles as a dead cycle on the bus.
    assign req     = wb_cyc_i & wb_stb_i & ~ack_q;
    assign busy    = (state_q != ST_IDLE);
    assign off     = wb_adr_i[4:2];
    assign is_data = (off == OFF_DATA16) || (off == OFF_DATA32);

`ifdef SFIFO_WR_CNT_EN
    // Push counter: a clear in the same cycle as a push still counts that push.
    always_comb begin
        cnt_d = (cnt_clr ? 32'd0 : cnt_q) + {31'd0, wr_q};
    end

    // Push counter register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Read data mux; DATA16/DATA32 and the unused offsets read back as zero.
    always_comb begin
        rd_data = '0;
        case (off)
            OFF_CTRL: begin
                rd_data[2] = abort_q;
                rd_data[1] = busy;
                rd_data[0] = sfifo_full_i;
            end
`ifdef SFIFO_WR_CNT_EN
            OFF_CNT: rd_data = WB_DW'(cnt_q);
`endif
            default: rd_data = '0;
        endcase
    end

    // Transfer FSM: decides pushes, acks, read data and abort set/clear.
    always_comb begin
        state_d   = state_q;
        ack_d     = 1'b0;
        dat_d     = dat_q;
        wr_d      = 1'b0;
        do_d      = do_q;
        hi_d      = hi_q;
        abort_set = 1'b0;
        abort_clr = 1'b0;
`ifdef SFIFO_WR_CNT_EN
        cnt_clr   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (!wb_we_i) begin
                        ack_d = 1'b1;
                        dat_d = rd_data;
                    end else if (is_data) begin
                        // Stall (no ack) while full; the wr_q term keeps a
                        // gap after a push that completed an aborted pair.
                        if (!sfifo_full_i && !wr_q) begin
                            wr_d = 1'b1;
                            do_d = wb_dat_i[SFIFO_DW-1:0];
                            if (off == OFF_DATA32) begin
                                hi_d    = wb_dat_i[WB_DW-1:SFIFO_DW];
                                state_d = ST_GAP;
                            end else begin
                                ack_d = 1'b1;
                            end
                        end
                    end else begin
                        ack_d = 1'b1;
                        if ((off == OFF_CTRL) && wb_dat_i[2]) begin
                            abort_clr = 1'b1;
                        end
`ifdef SFIFO_WR_CNT_EN
                        if (off == OFF_CNT) begin
                            cnt_clr = 1'b1;
                        end
`endif
                    end
                end
            end
            ST_GAP: begin
                // Low half is on the FIFO port this cycle; full is re-sampled
                // in HI once it has been accounted for.
                state_d = ST_HI;
            end
            ST_HI: begin
                if (!sfifo_full_i) begin
                    wr_d    = 1'b1;
                    do_d    = hi_q;
                    state_d = ST_IDLE;
                    if (wb_cyc_i && wb_stb_i) begin
                        ack_d = 1'b1;
                    end else begin
                        abort_set = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky abort flag; a set in the same cycle as a clear wins.
    always_comb begin
        abort_d = abort_set | (abort_q & ~abort_clr);
    end

    // State and output registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            dat_q   <= '0;
            wr_q    <= 1'b0;
            do_q    <= '0;
            hi_q    <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            wr_q    <= wr_d;
            do_q    <= do_d;
            hi_q    <= hi_d;
            abort_q <= abort_d;
        end
    end

    assign wb_ack_o   = ack_q;
    assign wb_dat_o   = dat_q;
    assign sfifo_wr_o = wr_q;
    assign sfifo_do   = do_q;

endmodule

// File: doc/sfifo_wr_if_top.md
Name: sfifo_wr_if_top

Overview:
Wishbone slave that turns host writes into pushes on a synchronous FIFO. It carries the command stream in the direction opposite to the sync-FIFO read interface: host to motion/IO logic, covering SYNC_JNT, SYNC_DOUT and SYNC_DI command words.
Host writes 16-bit entries directly, or 32-bit words split into two entries (low half first). It stalls wb_ack_o while the FIFO is full and reports status through a control register.

Parameters:
WB_LAW, 5, Wishbone lower address bits; offset decode uses adr[4:2]
WB_DW, 32, Wishbone data width
SFIFO_DW, 16, FIFO entry width; must be WB_DW/2

Ports:
wb_clk_i  in  1  single clock (FIFO write side shares this clock)
wb_rst_i  in  1  asynchronous, active-high reset
wb_cyc_i  in  1  WB cycle
wb_stb_i  in  1  WB strobe
wb_we_i  in  1  WB write enable
wb_sel_i  in  4  byte selects (ignored; full-word access only)
wb_adr_i  in  WB_LAW  lower address bits
wb_dat_i  in  WB_DW  write data
wb_dat_o  out  WB_DW  registered read data
wb_ack_o  out  1  registered acknowledge, one-cycle pulse
sfifo_wr_o  out  1  FIFO push strobe, registered
sfifo_do  out  SFIFO_DW  FIFO push data, valid when sfifo_wr_o=1
sfifo_full_i  in  1  FIFO full; reflects pushes up to the previous cycle

Behaviour:
- Register map, adr[4:2]:
  - 0 DATA16 (W): push wb_dat_i[15:0]
  - 1 DATA32 (W): push [15:0], then [31:16]
  - 2 CTRL: read {29'd0, abort, busy, sfifo_full_i}; write with bit2=1 clears abort
  - 3 CNT (see optional feature)
  - 4-7: reads return 0, writes are ignored but acked
- Reads of DATA16/DATA32 return 0.
- Request: req = cyc & stb & ~wb_ack_o.
- Reset (async): FSM=IDLE, wb_ack_o=0, wb_dat_o=0, sfifo_wr_o=0, sfifo_do=0, abort=0, latched word=0. Reset mid-transfer drops any pending high half.
- sfifo_wr_o is a single-cycle pulse. The block never pushes on two consecutive cycles; a 1-cycle gap re-samples sfifo_full_i.
- FSM states: IDLE, GAP, HI.
- IDLE:
  - Read or non-DATA write with req: ack at t+1, wb_dat_o updated at t+1.
  - DATA16 write with req & ~full: at t+1 sfifo_wr_o=1, sfifo_do=dat[15:0], ack=1; stay IDLE (the ack cycle blocks req, giving the gap).
  - DATA32 write with req & ~full: latch dat[31:16]; at t+1 push the low half, no ack; go to GAP.
  - DATA write with req & full: no push, no ack; wait in IDLE until full=0.
- GAP: one cycle, then HI.
- HI:
  - If ~full: push the latched high half next cycle.
    - If cyc&stb are still high: ack in the same cycle as the push.
    - If not: set abort and do not ack.
    - Either way, return to IDLE.
  - If full: wait in HI.
- Master abort (cyc or stb drops):
  - In IDLE while stalled: nothing is pushed.
  - After the low half is pushed: the high half is still pushed (pair integrity), abort is set, no ack.
- busy = (FSM != IDLE).
- Latency from first req cycle with FIFO not full:
  - DATA16: ack at +1.
  - DATA32: low push at +1, high push and ack at +3.
  - Reads/CTRL: ack at +1.
- abort clear in the same cycle as abort set: set wins.

Optional Feature:
SFIFO_WR_CNT_EN:
- Defined: a 32-bit push counter increments on each sfifo_wr_o=1 and wraps 0xFFFFFFFF to 0. Read at CNT; any write to CNT clears it to 0. A clear coinciding with a push leaves it at 1.
- Undefined: CNT reads 0, writes are ignored, no counter logic is built.

Test Plan:
- Reset, full=0, write DATA16 0x0000_1234 -> ack at +1, one pulse with sfifo_do=0x1234; CTRL reads 0x0.
- Write DATA32 0xBEEF_CAFE, full=0 -> push 0xCAFE at +1, gap at +2, push 0xBEEF with ack at +3; exactly 2 pulses.
- full=1, write DATA16 0x00AA, release full after 5 cycles -> no ack/push while full; push 0x00AA and ack 1 cycle after full drops.
- DATA32 0x1111_2222, full=1 after the low push, drop cyc during the stall, release full -> 0x1111 still pushed, no ack, CTRL=0x4; write CTRL 0x4 -> CTRL=0x0.
- Assert reset in GAP of DATA32 -> sfifo_wr_o=0 immediately, no high push after release, busy=0.
- With SFIFO_WR_CNT_EN: 3 DATA16 + 1 DATA32 -> CNT=5; write CNT -> 0; without the macro CNT=0 throughout.
